// File: rtl/pe_row_mac_pkg.sv
// Shared constants, FSM encoding and int8 saturation limits for the PE row MAC.
package pe_row_mac_pkg;
  localparam int LANES   = 16;
  localparam int DW      = 8;
  localparam int AW      = 24;
  localparam int SAT_MAX = 127;
  localparam int SAT_MIN = -128;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_POST = 2'd2,
    ST_HOLD = 2'd3
  } state_t;
endpackage

// File: rtl/pe_row_mac_if.sv
// Beat input, window config, result output and status of the PE row MAC.
interface pe_row_mac_if;
  import pe_row_mac_pkg::*;

  // in_vld/in_rdy and out_vld/out_rdy: a transfer happens on a rising clock edge
  // where both are high; out_data holds steady while out_vld is high and out_rdy low.
  logic [7:0]          K;
  logic [4:0]          shift;
  logic                relu_en;
  logic [AW-1:0]       bias;
  logic [LANES*DW-1:0] act_data;
  logic [DW-1:0]       wt_data;
  logic                in_vld;
  logic                in_rdy;
  logic                pe_end;
  logic [LANES*DW-1:0] out_data;
  logic                out_vld;
  logic                out_rdy;
  logic                err_drop;
  state_t              state;

  modport master (
    output K, shift, relu_en, bias, act_data, wt_data, in_vld, out_rdy,
    input  in_rdy, pe_end, out_data, out_vld, err_drop, state
  );
  modport slave (
    input  K, shift, relu_en, bias, act_data, wt_data, in_vld, out_rdy,
    output in_rdy, pe_end, out_data, out_vld, err_drop, state
  );
endinterface

// File: rtl/pe_row_mac_lane_requant.sv
// One MAC lane: accumulator plus bias add, arithmetic shift, int8 saturation and ReLU.
module pe_lane_requant
  import pe_row_mac_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 load,
  input  logic                 accum,
  input  logic                 clear,
  input  logic                 post,
  input  logic signed [DW-1:0] act,
  input  logic signed [DW-1:0] wt,
  input  logic signed [AW-1:0] bias,
  input  logic [4:0]           shift,
  input  logic                 relu_en,
  output logic signed [DW-1:0] res
);
  localparam logic signed [AW:0] HI = (AW+1)'(SAT_MAX);
  localparam logic signed [AW:0] LO = (AW+1)'(SAT_MIN);

  logic signed [AW-1:0]   acc;
  logic signed [2*DW-1:0] prod;
  logic signed [AW-1:0]   prod_ext;
  logic signed [AW:0]     biased;
  logic signed [AW:0]     shifted;
  logic signed [DW-1:0]   sat;

  assign prod     = act * wt;
  assign prod_ext = {{(AW-2*DW){prod[2*DW-1]}}, prod};
  // One extra bit so acc+bias cannot wrap before the shift.
  assign biased   = {acc[AW-1], acc} + {bias[AW-1], bias};
  assign shifted  = biased >>> shift;

  always_comb begin
    sat = shifted[DW-1:0];
    if (relu_en && shifted[AW])
      sat = '0;
    else if (shifted > HI)
      sat = DW'(SAT_MAX);
    else if (shifted < LO)
      sat = DW'(SAT_MIN);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      res <= '0;
    end else begin
      if (load)
        acc <= prod_ext;
      else if (accum)
        acc <= acc + prod_ext;
      else if (clear)
        acc <= '0;
      if (post)
        res <= sat;
    end
  end
endmodule

// File: rtl/pe_row_mac.sv
// Row of 16 MAC lanes: window FSM, tap counter, handshakes and drop flag around the lanes.
module pe_row_mac
  import pe_row_mac_pkg::*;
(
  input  logic         clk_cal,
  input  logic         rst_cal,
  pe_row_mac_if.slave  bus
);
  state_t         state, state_nxt;
  logic [7:0]     tap_cnt, k_lat, k_eff;
  logic [4:0]     shift_lat;
  logic           relu_lat;
  logic [AW-1:0]  bias_lat;
  logic           err_drop;
  logic           load, accum, clear, post;
  logic [DW-1:0]  lane_res [LANES];

  assign k_eff = (bus.K == 8'd0) ? 8'd1 : bus.K;

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    accum     = 1'b0;
    clear     = 1'b0;
    post      = 1'b0;
    case (state)
      ST_IDLE: if (bus.in_vld) begin
        load      = 1'b1;
        state_nxt = (k_eff == 8'd1) ? ST_POST : ST_ACC;
      end
      ST_ACC: if (bus.in_vld) begin
        accum = 1'b1;
        if (tap_cnt + 8'd1 == k_lat)
          state_nxt = ST_POST;
      end
      ST_POST: begin
        post      = 1'b1;
        state_nxt = ST_HOLD;
      end
      ST_HOLD: if (bus.out_rdy) begin
        clear     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_cal or posedge rst_cal) begin
    if (rst_cal) begin
      state     <= ST_IDLE;
      tap_cnt   <= '0;
      k_lat     <= 8'd1;
      shift_lat <= '0;
      relu_lat  <= 1'b0;
      bias_lat  <= '0;
      err_drop  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        tap_cnt   <= 8'd1;
        k_lat     <= k_eff;
        shift_lat <= bus.shift;
        relu_lat  <= bus.relu_en;
        bias_lat  <= bus.bias;
      end else if (accum) begin
        tap_cnt <= tap_cnt + 8'd1;
      end else if (clear) begin
        tap_cnt <= '0;
      end
      // Beats offered while busy are lost; remember that until reset.
      if (bus.in_vld && !bus.in_rdy)
        err_drop <= 1'b1;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    pe_lane_requant u_lane (
      .clk     (clk_cal),
      .rst     (rst_cal),
      .load    (load),
      .accum   (accum),
      .clear   (clear),
      .post    (post),
      .act     (bus.act_data[i*DW +: DW]),
      .wt      (bus.wt_data),
      .bias    (bias_lat),
      .shift   (shift_lat),
      .relu_en (relu_lat),
      .res     (lane_res[i])
    );
    assign bus.out_data[i*DW +: DW] = lane_res[i];
  end

  assign bus.in_rdy   = (state == ST_IDLE) || (state == ST_ACC);
  assign bus.pe_end   = (state == ST_POST);
  assign bus.out_vld  = (state == ST_HOLD);
  assign bus.err_drop = err_drop;
  assign bus.state    = state;
endmodule

// File: tb/tb_pe_row_mac.sv
// Randomised bench for pe_row_mac with a plain-arithmetic window model and output scoreboard.
module tb_pe_row_mac;
  import pe_row_mac_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  pe_row_mac_if bus();
  pe_row_mac dut (.clk_cal(clk), .rst_cal(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [LANES*DW-1:0] exp_q[$];
  int exp_pe_end  = 0;
  int seen_pe_end = 0;
  bit rdy_hold    = 1'b0;
  logic [LANES*DW-1:0] fx_act[8];
  logic [7:0]          fx_wt[8];

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s got=timeout exp=event", name);
  endtask

  function automatic longint wrap24(input longint v);
    longint m;
    m = v & 64'hFFFFFF;
    if (m >= 64'h800000) m = m - 64'h1000000;
    return m;
  endfunction

  // Reference: sum of products, plus bias, floor-divide by 2^shift, clamp to int8 (or [0,127]).
  function automatic logic [127:0] ref_window(input longint acc[LANES], input int bias,
                                              input int sh, input bit relu);
    logic [127:0] res;
    longint r;
    res = '0;
    for (int l = 0; l < LANES; l++) begin
      r = wrap24(acc[l]) + longint'(bias);
      r = r >>> sh;
      if (r > 127) r = 127;
      if (r < -128) r = -128;
      if (relu && r < 0) r = 0;
      res[l*8 +: 8] = 8'(r);
    end
    return res;
  endfunction

  function automatic logic [127:0] rand_act();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic wait_idle();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.in_rdy && n < 300);
    if (n >= 300) fail_now("idle_timeout");
    @(posedge clk); #1;
  endtask

  task automatic run_window(input int k, input int bias, input int sh, input bit relu,
                            input int gap_max, input bit use_fx, input bit wait_done);
    longint acc[LANES];
    int keff;
    logic [127:0] act;
    logic [7:0] wt;
    byte a, w;
    keff = (k == 0) ? 1 : k;
    for (int l = 0; l < LANES; l++) acc[l] = 0;
    for (int b = 0; b < keff; b++) begin
      if (b > 0) begin
        repeat ($urandom_range(0, gap_max)) begin
          bus.in_vld   = 1'b0;
          bus.act_data = rand_act();
          @(posedge clk); #1;
        end
      end
      act = use_fx ? fx_act[b] : rand_act();
      wt  = use_fx ? fx_wt[b] : 8'($urandom);
      bus.act_data = act;
      bus.wt_data  = wt;
      bus.in_vld   = 1'b1;
      if (b == 0) begin
        bus.K       = 8'(k);
        bus.shift   = 5'(sh);
        bus.relu_en = relu;
        bus.bias    = AW'(bias);
      end else begin
        bus.K       = 8'($urandom);
        bus.shift   = 5'($urandom);
        bus.relu_en = 1'($urandom);
        bus.bias    = AW'($urandom);
      end
      w = wt;
      for (int l = 0; l < LANES; l++) begin
        a = act[l*8 +: 8];
        acc[l] += longint'(a) * longint'(w);
      end
      @(posedge clk); #1;
    end
    bus.in_vld = 1'b0;
    exp_q.push_back(ref_window(acc, bias, sh, relu));
    exp_pe_end++;
    @(negedge clk);
    check("pe_end_latency", bus.pe_end, 1'b1);
    if (wait_done) wait_idle();
  endtask

  // Downstream acceptance: random unless a test is holding it off.
  initial begin
    bus.out_rdy = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.out_rdy = rdy_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: pops the scoreboard on every output handshake.
  initial begin
    logic [127:0] prev_data;
    bit prev_stall, prev_pe, prev_vld;
    prev_data = '0; prev_stall = 0; prev_pe = 0; prev_vld = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 0; prev_pe = 0; prev_vld = 0;
        continue;
      end
      if (bus.pe_end) seen_pe_end++;
      if (prev_stall && bus.out_vld) check("hold_stable", bus.out_data, prev_data);
      if (bus.out_vld && !prev_vld) check("vld_after_pe_end", prev_pe, 1'b1);
      if (bus.out_vld && bus.out_rdy) begin
        if (exp_q.size() == 0) fail_now("unexpected_out");
        else check("out_data", bus.out_data, exp_q.pop_front());
      end
      prev_stall = bus.out_vld && !bus.out_rdy;
      prev_data  = bus.out_data;
      prev_pe    = bus.pe_end;
      prev_vld   = bus.out_vld;
    end
  end

  initial begin
    int n;
    rst = 1'b1;
    bus.K = 8'd1; bus.shift = '0; bus.relu_en = 1'b0; bus.bias = '0;
    bus.act_data = '0; bus.wt_data = '0; bus.in_vld = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_rdy", bus.in_rdy, 1'b1);
    check("rst_out_vld", bus.out_vld, 1'b0);
    check("rst_pe_end", bus.pe_end, 1'b0);
    check("rst_out_data", bus.out_data, '0);
    check("rst_err_drop", bus.err_drop, 1'b0);
    check("rst_state", bus.state, ST_IDLE);
    rst = 1'b0;
    @(posedge clk); #1;

    // All lanes act=2, weights 1,2,3 -> 12
    for (int b = 0; b < 3; b++) begin
      fx_act[b] = {16{8'h02}};
      fx_wt[b]  = 8'(b + 1);
    end
    run_window(3, 0, 0, 0, 0, 1, 1);

    // Saturation at both ends with K=1
    fx_act[0] = rand_act();
    fx_act[0][7:0]  = 8'd127;
    fx_act[0][15:8] = 8'h80;
    fx_wt[0] = 8'd127;
    run_window(1, 0, 0, 0, 0, 1, 1);

    // (-100+20)>>>2 = -20, then the same with ReLU
    for (int b = 0; b < 2; b++) begin
      fx_act[b] = {16{8'hF6}};
      fx_wt[b]  = 8'd5;
    end
    run_window(2, 20, 2, 0, 0, 1, 1);
    run_window(2, 20, 2, 1, 0, 1, 1);

    // Same K=4 window with and without gaps
    for (int b = 0; b < 4; b++) begin
      fx_act[b] = rand_act();
      fx_wt[b]  = 8'($urandom);
    end
    run_window(4, 37, 3, 0, 0, 1, 1);
    run_window(4, 37, 3, 0, 3, 1, 1);

    // Backpressure: output stalled while beats keep arriving
    rdy_hold = 1'b1;
    run_window(2, 0, 1, 0, 0, 0, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.out_vld && n < 20);
    if (n >= 20) fail_now("out_vld_timeout");
    repeat (5) begin
      @(posedge clk); #1;
      bus.in_vld   = 1'b1;
      bus.act_data = rand_act();
      bus.wt_data  = 8'($urandom);
      @(negedge clk);
      check("stall_in_rdy", bus.in_rdy, 1'b0);
      check("stall_out_vld", bus.out_vld, 1'b1);
    end
    @(posedge clk); #1;
    bus.in_vld = 1'b0;
    @(negedge clk);
    check("err_drop_set", bus.err_drop, 1'b1);
    rdy_hold = 1'b0;
    n = 0;
    do begin @(negedge clk); n++; end while (!(bus.out_vld && bus.out_rdy) && n < 50);
    if (n >= 50) fail_now("release_timeout");
    @(negedge clk);
    check("idle_after_hs", bus.in_rdy, 1'b1);
    @(posedge clk); #1;
    run_window(3, -50, 2, 1, 1, 0, 1);
    check("err_drop_sticky", bus.err_drop, 1'b1);

    // Randomised windows, K=0 included
    for (int t = 0; t < 24; t++)
      run_window($urandom_range(0, 9), int'($urandom_range(0, 8000)) - 4000,
                 $urandom_range(0, 10), 1'($urandom), 2, 0, 1);

    // Reset part-way through a K=5 window
    bus.K = 8'd5; bus.shift = '0; bus.relu_en = 1'b0; bus.bias = '0;
    repeat (2) begin
      bus.act_data = rand_act();
      bus.wt_data  = 8'($urandom);
      bus.in_vld   = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_vld = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("midrst_out_vld", bus.out_vld, 1'b0);
    check("midrst_pe_end", bus.pe_end, 1'b0);
    check("midrst_in_rdy", bus.in_rdy, 1'b1);
    check("midrst_out_data", bus.out_data, '0);
    check("midrst_err_drop", bus.err_drop, 1'b0);
    check("midrst_state", bus.state, ST_IDLE);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk); #1;
    run_window(2, 0, 0, 0, 0, 0, 1);
    run_window(2, 100, 4, 0, 1, 0, 1);

    n = 0;
    while (exp_q.size() != 0 && n < 100) begin @(negedge clk); n++; end
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("pe_end_count", 32'(seen_pe_end), 32'(exp_pe_end));
    check("final_err_drop", bus.err_drop, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/pe_row_mac.md
Name: pe_row_mac

Overview:
- Row of 16 multiply-accumulate lanes directly downstream of the input register file.
- Consumes the 16 stride-spaced activation bytes plus one broadcast weight byte per valid beat.
- Accumulates over K kernel taps, then applies bias, right-shift requantisation, int8 saturation and optional ReLU.
- Returns the 16 requantised outputs to the In/Out buffer write path. Generates pe_end back to the register file to rewind its read address.

Parameters:
- LANES, 16, number of parallel output positions (one per activation byte).
- DW, 8, activation/weight/output width (signed two's complement).
- AW, 24, accumulator width. Holds 255 products of 16 bits without overflow.

Ports:
- clk_cal  in  1  calculation clock; all state on rising edge.
- rst_cal  in  1  asynchronous, active-high reset.
- K  in  8  kernel length in taps; sampled on the first beat of a window; 0 treated as 1.
- shift  in  5  arithmetic right-shift amount applied after bias add; sampled with K.
- relu_en  in  1  clamp negative results to 0; sampled with K.
- bias  in  AW  signed bias added once per window; sampled with K.
- act_data  in  LANES*DW  lane i on bits [8i+7:8i], signed.
- wt_data  in  DW  signed weight broadcast to all lanes.
- in_vld  in  1  act_data/wt_data valid this cycle.
- in_rdy  out  1  block accepts beats; low in POST and HOLD.
- pe_end  out  1  one-cycle pulse the cycle after the K-th beat is accepted.
- out_data  out  LANES*DW  requantised int8 results, same lane packing.
- out_vld  out  1  out_data valid; held until out_rdy.
- out_rdy  in  1  downstream accepts out_data when out_vld&&out_rdy.
- err_drop  out  1  sticky: a beat arrived with in_rdy low; cleared only by reset.

Behaviour:
- Reset values: all accumulators 0, tap counter 0, state IDLE, in_rdy 1, pe_end 0, out_vld 0, out_data 0, err_drop 0.
- States: IDLE, ACC, POST, HOLD.
- IDLE:
  - On in_vld, latch K (0→1), shift, relu_en, bias.
  - Set acc[i] = act[i]*wt sign-extended to AW, and tap count = 1.
  - If latched K==1, go to POST; else go to ACC.
- ACC:
  - Each in_vld: acc[i] += act[i]*wt and tap count increments.
  - On the beat where count reaches K, go to POST.
  - Gaps (in_vld low) do not advance the count.
- POST (one cycle):
  - pe_end=1.
  - r[i] = (acc[i]+bias) >>> shift, computed at AW+1 bits; arithmetic shift, truncating toward -inf.
  - Saturate to [-128,127]; if relu_en, clamp to [0,127].
  - Register into out_data, out_vld=1, go to HOLD.
- HOLD:
  - On out_rdy: out_vld→0, accumulators cleared, go to IDLE.
  - The next window's first beat may arrive the cycle after the handshake.
- Latency: last tap beat at cycle t → pe_end at t+1 → out_vld at t+2.
- Backpressure: in_rdy = (state==IDLE||state==ACC). in_vld with in_rdy low: beat discarded, err_drop set, state unaffected.
- out_data is stable while out_vld&&!out_rdy.
- Product width 16 bits, signed×signed. Accumulation wraps mod 2^AW; no overflow detection beyond AW.
- Reset asserted mid-window: all state returns to reset values immediately (asynchronous); a partial window is lost and no pe_end is issued.
- K/shift/bias changes mid-window are ignored until the next IDLE.

Decomposition:
- Shared package: LANES, DW, AW constants; state encoding (2 bits); int8 saturation limits (SAT_MAX=127, SAT_MIN=-128).
- Natural sub-module: pe_lane_requant. One instance per lane, holding the accumulator plus bias/shift/saturate/ReLU logic; top-level keeps the FSM, tap counter, handshake and err_drop.

Test Plan:
- Reset then K=3, bias=0, shift=0, relu_en=0; lanes all act=2, wt={1,2,3} on three consecutive beats → pe_end one cycle after beat 3; out_vld next cycle; every lane =12.
- K=1, act lane0=127, wt=127, bias=0, shift=0 → lane0 saturates to 127. Lane1 act=-128, wt=127 → -128.
- K=2, act=-10 all lanes, wt=5 twice, bias=20, shift=2 → (-100+20)>>>2 = -20. With relu_en=1 → 0.
- K=4 with in_vld gaps between beats → result identical to gap-free run; pe_end exactly once.
- Hold out_rdy low 5 cycles after out_vld while driving in_vld → out_data stable, in_rdy 0, err_drop rises and stays 1. Release out_rdy → IDLE next cycle, new window accepted.
- Assert rst_cal after 2 of K=5 beats → outputs zero immediately. Fresh K=2 window then yields correct result with no stale accumulation.
